// File: rtl/csr_pkg.sv
// Shared CSR-unit definitions: interrupt cause encoding, MIE layout and the
// trap-sequencing state type used by irq_controller.
package csr_pkg;

    // mcause for external interrupt k is IRQ_CAUSE_BASE + k (interrupt bit set)
    localparam logic [31:0] IRQ_CAUSE_BASE = 32'h8000_0010;
    localparam int          MIE_IRQ_LSB    = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTRY   = 2'd1,
        SERVICE = 2'd2,
        RETURN  = 2'd3
    } irq_state_t;

    function automatic logic [31:0] irq_cause(input logic [31:0] idx);
        return IRQ_CAUSE_BASE + idx;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set request index wins.
module irq_prio_enc #(
    parameter int IRQ_NUM = 16,
    parameter int ID_W    = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1
) (
    input  logic [IRQ_NUM-1:0] req,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    // Scan from the top down so the last hit, the lowest index, is kept.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Machine-mode interrupt controller: edge-latches requests, masks with MIE,
// sequences one non-nested trap entry and acknowledges the source on mret.
module irq_controller
    import csr_pkg::*;
#(
    parameter int IRQ_NUM = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IRQ_NUM-1:0] irq_req_i,
    input  logic [31:0]        mie_i,
    input  logic               exception_i,
    input  logic               stall_i,
    input  logic               mret_i,
    output logic               irq_o,
    output logic [31:0]        irq_cause_o,
    output logic [IRQ_NUM-1:0] irq_ret_o,
    output logic               busy_o
);

    localparam int ID_W = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;
    localparam logic [31:0] MIE_USED =
        {{(32 - IRQ_NUM){1'b0}}, {IRQ_NUM{1'b1}}} << MIE_IRQ_LSB;

    logic [IRQ_NUM-1:0] req_d;
    logic [IRQ_NUM-1:0] pending;
    logic [IRQ_NUM-1:0] rise;
    logic [IRQ_NUM-1:0] mie_irq;
    logic [IRQ_NUM-1:0] eligible;
    logic [IRQ_NUM-1:0] clr;
    logic [IRQ_NUM-1:0] cur_onehot;
    logic               enc_valid;
    logic [ID_W-1:0]    enc_id;
    logic [ID_W-1:0]    cur_id;
    logic               unused_mie;
    irq_state_t         state;

    assign mie_irq    = mie_i[MIE_IRQ_LSB +: IRQ_NUM];
    assign unused_mie = |(mie_i & ~MIE_USED);

    assign rise       = irq_req_i & ~req_d;
    assign eligible   = pending & mie_irq;
    assign cur_onehot = {{(IRQ_NUM - 1){1'b0}}, 1'b1} << cur_id;

    irq_prio_enc #(
        .IRQ_NUM (IRQ_NUM),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req   (eligible),
        .valid (enc_valid),
        .id    (enc_id)
    );

    always_comb begin
        clr = '0;
        if (state == SERVICE && mret_i) begin
            clr = cur_onehot;
        end
    end

    // A new edge on the serviced source in the mret cycle outranks the clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_d   <= '0;
            pending <= '0;
        end else begin
            req_d   <= irq_req_i;
            pending <= (pending & ~clr) | rise;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cur_id      <= '0;
            irq_o       <= 1'b0;
            irq_cause_o <= '0;
            irq_ret_o   <= '0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enc_valid && !exception_i && !stall_i) begin
                        cur_id      <= enc_id;
                        irq_cause_o <= irq_cause(32'(enc_id));
                        irq_o       <= 1'b1;
                        state       <= ENTRY;
                    end
                end
                ENTRY: begin
                    irq_o  <= 1'b0;
                    busy_o <= 1'b1;
                    state  <= SERVICE;
                end
                SERVICE: begin
                    if (mret_i) begin
                        irq_ret_o <= cur_onehot;
                        busy_o    <= 1'b0;
                        state     <= RETURN;
                    end
                end
                RETURN: begin
                    irq_ret_o <= '0;
                    state     <= IDLE;
                end
                default: begin
                    irq_o     <= 1'b0;
                    irq_ret_o <= '0;
                    busy_o    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
